// File: rtl/updw_cnt_pkg.sv
// Shared mode encodings for the multi-mode up/down/bounce counter.
package updw_cnt_pkg;

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DN   = 2'b01;
  localparam logic [1:0] MODE_BNC  = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

endpackage

// File: rtl/updw_cnt_nxt.sv
// Combinational step function: next count, direction and terminal-count for one enabled step.
// Assumes lo <= hi; the caller holds state when the bounds are inverted.
module updw_cnt_nxt
  import updw_cnt_pkg::*;
#(
  parameter int BW = 8
) (
  input  logic [BW-1:0] cnt,
  input  logic          dir,
  input  logic [1:0]    mode,
  input  logic          wrap,
  input  logic [BW-1:0] lo,
  input  logic [BW-1:0] hi,
  output logic [BW-1:0] nxt_cnt,
  output logic          nxt_dir,
  output logic          nxt_tc
);

  logic up;
  logic bnc;

  always_comb begin
    up = dir;
    if (mode == MODE_UP) begin
      up = 1'b1;
    end else if (mode == MODE_DN) begin
      up = 1'b0;
    end
    bnc     = (mode == MODE_BNC);
    nxt_cnt = cnt;
    nxt_dir = up;
    nxt_tc  = 1'b0;

    if (mode == MODE_HOLD) begin
      nxt_dir = dir;
    end else if (lo == hi) begin
      // Single-point range: pin to the bound and pulse every step, never flip.
      nxt_cnt = lo;
      nxt_tc  = 1'b1;
    end else if ((cnt < lo) || (cnt > hi)) begin
      nxt_cnt = up ? lo : hi;
    end else if (up) begin
      if (cnt != hi) begin
        nxt_cnt = cnt + 1'b1;
      end else begin
        nxt_tc = 1'b1;
        if (bnc) begin
          nxt_dir = 1'b0;
          nxt_cnt = hi - 1'b1;
        end else if (wrap) begin
          nxt_cnt = lo;
        end
      end
    end else begin
      if (cnt != lo) begin
        nxt_cnt = cnt - 1'b1;
      end else begin
        nxt_tc = 1'b1;
        if (bnc) begin
          nxt_dir = 1'b1;
          nxt_cnt = lo + 1'b1;
        end else if (wrap) begin
          nxt_cnt = hi;
        end
      end
    end
  end

endmodule

// File: rtl/updw_cnt_multi.sv
// Runtime-bounded up/down/bounce counter with wrap/saturate, load, enable and boundary flags.
// Register stage with reset > load > inverted-bounds hold > enabled step priority.
module updw_cnt_multi
  import updw_cnt_pkg::*;
#(
  parameter int            BW      = 8,
  parameter logic [BW-1:0] RST_VAL = '0
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  input  logic [1:0]    i_mode,
  input  logic          i_wrap,
  input  logic [BW-1:0] i_lo,
  input  logic [BW-1:0] i_hi,
  input  logic          i_load,
  input  logic [BW-1:0] i_ld_val,
  output logic [BW-1:0] o_cnt,
  output logic          o_dir,
  output logic          o_tc,
  output logic          o_err
);

  logic [BW-1:0] cnt_p1;
  logic          dir_p1;
  logic          tc_p1;
  logic          err_p1;

  logic [BW-1:0] nxt_cnt;
  logic          nxt_dir;
  logic          nxt_tc;
  logic          bad_bounds;
  logic          step;

  assign bad_bounds = (i_lo > i_hi);
  assign step       = i_en && (i_mode != MODE_HOLD) && !bad_bounds;

  updw_cnt_nxt #(.BW(BW)) u_nxt (
    .cnt     (cnt_p1),
    .dir     (dir_p1),
    .mode    (i_mode),
    .wrap    (i_wrap),
    .lo      (i_lo),
    .hi      (i_hi),
    .nxt_cnt (nxt_cnt),
    .nxt_dir (nxt_dir),
    .nxt_tc  (nxt_tc)
  );

  // Stage p1: architectural state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_p1 <= RST_VAL;
      dir_p1 <= 1'b1;
      tc_p1  <= 1'b0;
      err_p1 <= 1'b0;
    end else begin
      err_p1 <= bad_bounds;
      tc_p1  <= 1'b0;
      if (i_load) begin
        cnt_p1 <= i_ld_val;
      end else if (step) begin
        cnt_p1 <= nxt_cnt;
        dir_p1 <= nxt_dir;
        tc_p1  <= nxt_tc;
      end
    end
  end

  assign o_cnt = cnt_p1;
  assign o_dir = dir_p1;
  assign o_tc  = tc_p1;
  assign o_err = err_p1;

endmodule

// File: tb/tb_updw_cnt_multi.sv
// Directed bench for updw_cnt_multi with BW=4, RST_VAL=0.
module tb_updw_cnt_multi;

  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [1:0]    mode;
  logic          wrap;
  logic [BW-1:0] lo;
  logic [BW-1:0] hi;
  logic          load;
  logic [BW-1:0] ld_val;
  logic [BW-1:0] cnt;
  logic          dir;
  logic          tc;
  logic          err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  updw_cnt_multi #(.BW(BW), .RST_VAL(4'd0)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_en     (en),
    .i_mode   (mode),
    .i_wrap   (wrap),
    .i_lo     (lo),
    .i_hi     (hi),
    .i_load   (load),
    .i_ld_val (ld_val),
    .o_cnt    (cnt),
    .o_dir    (dir),
    .o_tc     (tc),
    .o_err    (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [BW-1:0] v);
    load = 1'b1; ld_val = v;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; mode = 2'b00; wrap = 1'b1; lo = 4'd0; hi = 4'd15;
    load = 1'b0; ld_val = 4'd0;
    tick(); tick();
    rst = 1'b0;
    checks++; if (cnt !== 4'd0) begin errors++; $display("FAIL rst_cnt got %0d want 0", cnt); end
    checks++; if (dir !== 1'b1) begin errors++; $display("FAIL rst_dir got %0b want 1", dir); end
    checks++; if (tc !== 1'b0) begin errors++; $display("FAIL rst_tc got %0b want 0", tc); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %0b want 0", err); end
    // reset mid-count, with direction down and a live step request
    mode = 2'b01; en = 1'b1;
    do_load(4'd7);
    checks++; if (cnt !== 4'd7) begin errors++; $display("FAIL rst_mid_pre got %0d want 7", cnt); end
    tick();
    checks++; if (dir !== 1'b0) begin errors++; $display("FAIL rst_mid_dir0 got %0b want 0", dir); end
    rst = 1'b1;
    tick();
    rst = 1'b0; en = 1'b0;
    checks++; if (cnt !== 4'd0) begin errors++; $display("FAIL rst_mid_cnt got %0d want 0", cnt); end
    checks++; if (dir !== 1'b1) begin errors++; $display("FAIL rst_mid_dir got %0b want 1", dir); end
    checks++; if (tc !== 1'b0) begin errors++; $display("FAIL rst_mid_tc got %0b want 0", tc); end
  endtask

  task automatic test_up_wrap();
    logic [BW-1:0] ec [6] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd2, 4'd3};
    logic          et [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    lo = 4'd2; hi = 4'd5; mode = 2'b00; wrap = 1'b1; en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (cnt !== ec[i]) begin errors++; $display("FAIL up_wrap_cnt[%0d] got %0d want %0d", i, cnt, ec[i]); end
      checks++; if (tc !== et[i]) begin errors++; $display("FAIL up_wrap_tc[%0d] got %0b want %0b", i, tc, et[i]); end
    end
    en = 1'b0;
  endtask

  task automatic test_down_sat();
    logic [BW-1:0] ec [4] = '{4'd3, 4'd2, 4'd2, 4'd2};
    logic          et [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    lo = 4'd2; hi = 4'd5; mode = 2'b01; wrap = 1'b0; en = 1'b0;
    do_load(4'd4);
    checks++; if (cnt !== 4'd4) begin errors++; $display("FAIL dn_sat_load got %0d want 4", cnt); end
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (cnt !== ec[i]) begin errors++; $display("FAIL dn_sat_cnt[%0d] got %0d want %0d", i, cnt, ec[i]); end
      checks++; if (tc !== et[i]) begin errors++; $display("FAIL dn_sat_tc[%0d] got %0b want %0b", i, tc, et[i]); end
    end
    checks++; if (dir !== 1'b0) begin errors++; $display("FAIL dn_sat_dir got %0b want 0", dir); end
    en = 1'b0;
  endtask

  task automatic test_down_wrap();
    logic [BW-1:0] ec [3] = '{4'd2, 4'd5, 4'd4};
    logic          et [3] = '{1'b0, 1'b1, 1'b0};
    lo = 4'd2; hi = 4'd5; mode = 2'b01; wrap = 1'b1; en = 1'b0;
    do_load(4'd3);
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (cnt !== ec[i]) begin errors++; $display("FAIL dn_wrap_cnt[%0d] got %0d want %0d", i, cnt, ec[i]); end
      checks++; if (tc !== et[i]) begin errors++; $display("FAIL dn_wrap_tc[%0d] got %0b want %0b", i, tc, et[i]); end
    end
    en = 1'b0;
  endtask

  task automatic test_bounce();
    logic [BW-1:0] ec [7] = '{4'd2, 4'd3, 4'd4, 4'd3, 4'd2, 4'd1, 4'd2};
    logic          ed [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic          et [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    // out-of-range up step lands on lo=1 with dir=1
    lo = 4'd1; hi = 4'd4; mode = 2'b00; wrap = 1'b0; en = 1'b0;
    do_load(4'd0);
    en = 1'b1;
    tick();
    checks++; if (cnt !== 4'd1) begin errors++; $display("FAIL bnc_start got %0d want 1", cnt); end
    checks++; if (tc !== 1'b0) begin errors++; $display("FAIL bnc_start_tc got %0b want 0", tc); end
    mode = 2'b10;
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++; if (cnt !== ec[i]) begin errors++; $display("FAIL bnc_cnt[%0d] got %0d want %0d", i, cnt, ec[i]); end
      checks++; if (dir !== ed[i]) begin errors++; $display("FAIL bnc_dir[%0d] got %0b want %0b", i, dir, ed[i]); end
      checks++; if (tc !== et[i]) begin errors++; $display("FAIL bnc_tc[%0d] got %0b want %0b", i, tc, et[i]); end
    end
    en = 1'b0;
  endtask

  task automatic test_load_en();
    lo = 4'd0; hi = 4'd12; mode = 2'b00; wrap = 1'b1; en = 1'b1;
    do_load(4'd9);
    checks++; if (cnt !== 4'd9) begin errors++; $display("FAIL ld_en_cnt got %0d want 9", cnt); end
    tick();
    checks++; if (cnt !== 4'd10) begin errors++; $display("FAIL ld_en_step got %0d want 10", cnt); end
    do_load(4'd14);
    checks++; if (cnt !== 4'd14) begin errors++; $display("FAIL ld_oor_cnt got %0d want 14", cnt); end
    checks++; if (tc !== 1'b0) begin errors++; $display("FAIL ld_oor_tc0 got %0b want 0", tc); end
    tick();
    checks++; if (cnt !== 4'd0) begin errors++; $display("FAIL oor_up_cnt got %0d want 0", cnt); end
    checks++; if (tc !== 1'b0) begin errors++; $display("FAIL oor_up_tc got %0b want 0", tc); end
    do_load(4'd14);
    mode = 2'b01;
    tick();
    checks++; if (cnt !== 4'd12) begin errors++; $display("FAIL oor_dn_cnt got %0d want 12", cnt); end
    en = 1'b0;
  endtask

  task automatic test_hold();
    lo = 4'd0; hi = 4'd12; mode = 2'b11; en = 1'b1;
    do_load(4'd12);
    tick(); tick();
    checks++; if (cnt !== 4'd12) begin errors++; $display("FAIL hold_mode_cnt got %0d want 12", cnt); end
    checks++; if (tc !== 1'b0) begin errors++; $display("FAIL hold_mode_tc got %0b want 0", tc); end
    mode = 2'b00; en = 1'b0;
    tick();
    checks++; if (cnt !== 4'd12) begin errors++; $display("FAIL hold_en_cnt got %0d want 12", cnt); end
    checks++; if (tc !== 1'b0) begin errors++; $display("FAIL hold_en_tc got %0b want 0", tc); end
  endtask

  task automatic test_error();
    lo = 4'd6; hi = 4'd3; mode = 2'b00; wrap = 1'b1; en = 1'b1;
    tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_flag got %0b want 1", err); end
    checks++; if (cnt !== 4'd12) begin errors++; $display("FAIL err_hold got %0d want 12", cnt); end
    checks++; if (tc !== 1'b0) begin errors++; $display("FAIL err_tc got %0b want 0", tc); end
    do_load(4'd5);
    checks++; if (cnt !== 4'd5) begin errors++; $display("FAIL err_load got %0d want 5", cnt); end
    tick();
    checks++; if (cnt !== 4'd5) begin errors++; $display("FAIL err_hold2 got %0d want 5", cnt); end
    lo = 4'd7; hi = 4'd7;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (cnt !== 4'd7) begin errors++; $display("FAIL eq_cnt[%0d] got %0d want 7", i, cnt); end
      checks++; if (tc !== 1'b1) begin errors++; $display("FAIL eq_tc[%0d] got %0b want 1", i, tc); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL eq_err[%0d] got %0b want 0", i, err); end
    end
    mode = 2'b10;
    tick();
    checks++; if (dir !== 1'b1) begin errors++; $display("FAIL eq_bnc_dir got %0b want 1", dir); end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_sat();
    test_down_wrap();
    test_bounce();
    test_load_en();
    test_hold();
    test_error();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
